// File: rtl/wb_arb2_rr.sv
// Two-master, one-slave Wishbone arbiter with round-robin fairness and a
// per-transfer ack watchdog that terminates stalled transfers with err.
module wb_arb2_rr #(
    parameter int DW      = 32,
    parameter int AW      = 16,
    parameter int SW      = DW / 8,
    parameter int TIMEOUT = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n_i,

    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [SW-1:0] m0_sel_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack_o,
    output logic          m0_err_o,

    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [SW-1:0] m1_sel_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          m1_err_o,

    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [SW-1:0] s_sel_o,
    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,

    output logic [1:0]    grant_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_OWN0 = 2'd1;
    localparam logic [1:0] S_OWN1 = 2'd2;

    // Last wait count before the watchdog fires (count runs 0..TIMEOUT-1).
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    logic [1:0]    state_q, state_d;
    logic          last_q, last_d;      // 0 = m0 owned last, 1 = m1 owned last
    logic [15:0]   wd_q, wd_d;

    logic          own0, own1, owned;
    logic          own_cyc, own_stb, own_we;
    logic [SW-1:0] own_sel;
    logic [AW-1:0] own_adr;
    logic [DW-1:0] own_dat;
    logic          wd_run, timeout;

    // Owner selection: everything the slave sees comes from the owning master.
    always_comb begin
        own0    = (state_q == S_OWN0);
        own1    = (state_q == S_OWN1);
        owned   = own0 | own1;
        own_cyc = own1 ? m1_cyc_i : m0_cyc_i;
        own_stb = own1 ? m1_stb_i : m0_stb_i;
        own_we  = own1 ? m1_we_i  : m0_we_i;
        own_sel = own1 ? m1_sel_i : m0_sel_i;
        own_adr = own1 ? m1_adr_i : m0_adr_i;
        own_dat = own1 ? m1_dat_i : m0_dat_i;
        wd_run  = owned & own_stb & ~s_ack_i;
        timeout = wd_run & (wd_q == WD_LAST);
    end

    always_comb begin
        s_cyc_o  = owned & own_cyc & ~timeout;
        s_stb_o  = owned & own_stb & ~timeout;
        s_we_o   = owned & own_we;
        s_sel_o  = owned ? own_sel : '0;
        s_adr_o  = owned ? own_adr : '0;
        s_dat_o  = owned ? own_dat : '0;

        m0_ack_o = own0 & s_ack_i & m0_stb_i;
        m1_ack_o = own1 & s_ack_i & m1_stb_i;
        m0_err_o = own0 & timeout;
        m1_err_o = own1 & timeout;

        m0_dat_o = owned ? s_dat_i : '0;
        m1_dat_o = owned ? s_dat_i : '0;

        grant_o  = {own1, own0};
    end

    // A tie goes to whichever master did not own the bus last.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        wd_d    = '0;
        case (state_q)
            S_IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
                    state_d = S_OWN0;
                    last_d  = 1'b0;
                end else if (m1_cyc_i) begin
                    state_d = S_OWN1;
                    last_d  = 1'b1;
                end
            end
            S_OWN0, S_OWN1: begin
                if (timeout || !own_cyc) begin
                    state_d = S_IDLE;
                end else if (wd_run) begin
                    wd_d = wd_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
        end
    end

endmodule

// File: tb/tb_wb_arb2_rr.sv
// Bench for wb_arb2_rr: directed scenarios plus random traffic, all checked
// every cycle against an owner/wait-count model of the arbiter.
module tb_wb_arb2_rr;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  m_cyc, m_stb, m_we;
  logic [3:0]  m_sel [2];
  logic [15:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic [31:0] s_dat_i;
  logic        s_ack_i;

  logic [31:0] m0_dat_o, m1_dat_o, s_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [15:0] s_adr_o;
  logic [1:0]  grant_o;

  wb_arb2_rr #(.DW(32), .AW(16), .SW(4), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]),
    .m0_sel_i(m_sel[0]), .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]),
    .m1_sel_i(m_sel[1]), .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o)
  );

  // Model: who owns the bus (-1 = nobody), who owned it last, and how many
  // consecutive strobe cycles have gone unanswered.
  int owner = -1;
  int last_g = 1;
  int wcnt = 0;

  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  int grant_log[$];
  logic [1:0] prev_grant = 2'b00;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_timeout();
    return (owner >= 0) && m_stb[owner] && !s_ack_i && (wcnt == TO - 1);
  endfunction

  // Called just after the falling edge: outputs have settled for this cycle.
  task automatic settle();
    bit to;
    int o;
    #1;
    if (!rst_n || owner < 0) begin
      chk("grant", grant_o, 2'b00);
      chk("s_cyc", s_cyc_o, 0);
      chk("s_stb", s_stb_o, 0);
      chk("s_we", s_we_o, 0);
      chk("s_sel", s_sel_o, 0);
      chk("s_adr", s_adr_o, 0);
      chk("s_dat", s_dat_o, 0);
      chk("m0_ack", m0_ack_o, 0);
      chk("m1_ack", m1_ack_o, 0);
      chk("m0_err", m0_err_o, 0);
      chk("m1_err", m1_err_o, 0);
    end else begin
      o  = owner;
      to = model_timeout();
      chk("grant", grant_o, (o == 0) ? 2'b01 : 2'b10);
      chk("s_cyc", s_cyc_o, m_cyc[o] && !to);
      chk("s_stb", s_stb_o, m_stb[o] && !to);
      chk("s_we", s_we_o, m_we[o]);
      chk("s_sel", s_sel_o, m_sel[o]);
      chk("s_adr", s_adr_o, m_adr[o]);
      chk("s_dat", s_dat_o, m_dat[o]);
      chk("m0_ack", m0_ack_o, (o == 0) && s_ack_i && m_stb[0]);
      chk("m1_ack", m1_ack_o, (o == 1) && s_ack_i && m_stb[1]);
      chk("m0_err", m0_err_o, (o == 0) && to);
      chk("m1_err", m1_err_o, (o == 1) && to);
      if (s_ack_i && m_stb[o]) begin
        if (o == 0) chk("m0_rdata", m0_dat_o, s_dat_i);
        else        chk("m1_rdata", m1_dat_o, s_dat_i);
      end
    end
    if (grant_o != 2'b00 && prev_grant == 2'b00)
      grant_log.push_back(grant_o == 2'b01 ? 0 : 1);
    prev_grant = grant_o;
  endtask

  task automatic advance();
    bit to;
    if (!rst_n) begin
      owner = -1; last_g = 1; wcnt = 0;
    end else if (owner < 0) begin
      if (m_cyc[0] && m_cyc[1]) owner = 1 - last_g;
      else if (m_cyc[0])        owner = 0;
      else if (m_cyc[1])        owner = 1;
      if (owner >= 0) last_g = owner;
      wcnt = 0;
    end else begin
      to = model_timeout();
      if (to || !m_cyc[owner]) begin
        owner = -1; wcnt = 0;
      end else if (m_stb[owner] && !s_ack_i) begin
        wcnt++;
      end else begin
        wcnt = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic clear_inputs();
    m_cyc = 2'b00; m_stb = 2'b00; m_we = 2'b00;
    for (int i = 0; i < 2; i++) begin
      m_sel[i] = '0; m_adr[i] = '0; m_dat[i] = '0;
    end
    s_ack_i = 1'b0; s_dat_i = '0;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  int held [2];
  bit off [2];
  int n_ack0, n_ack1, pct;
  logic [31:0] e;

  initial begin
    clear_inputs();
    @(negedge clk);
    // Reset state
    settle();
    chk("rst grant", grant_o, 2'b00);
    chk("rst s_cyc", s_cyc_o, 0);
    advance();
    rst_n = 1'b1;
    step();

    // Single write, slave acks immediately
    m_cyc[0] = 1; m_stb[0] = 1; m_we[0] = 1; m_sel[0] = 4'hF;
    m_adr[0] = 16'h0004; m_dat[0] = 32'hDEADBEEF; s_ack_i = 1;
    settle();
    chk("t1 arb s_cyc", s_cyc_o, 0);
    chk("t1 arb grant", grant_o, 2'b00);
    advance();
    settle();
    chk("t1 s_cyc", s_cyc_o, 1);
    chk("t1 s_dat", s_dat_o, 32'hDEADBEEF);
    chk("t1 s_adr", s_adr_o, 16'h0004);
    chk("t1 s_sel", s_sel_o, 4'hF);
    chk("t1 m0_ack", m0_ack_o, 1);
    chk("t1 grant", grant_o, 2'b01);
    advance();
    clear_inputs();
    step();
    settle();
    chk("t1 grant after", grant_o, 2'b00);
    advance();

    // Round-robin alternation on repeated ties
    do_reset();
    grant_log.delete();
    held[0] = 0; held[1] = 0; off[0] = 0; off[1] = 0;
    for (int c = 0; c < 16; c++) begin
      for (int i = 0; i < 2; i++) m_cyc[i] = !off[i];
      settle();
      for (int i = 0; i < 2; i++) begin
        if (grant_o[i] && m_cyc[i]) held[i]++;
        off[i] = (held[i] == 3);
        if (off[i]) held[i] = 0;
      end
      advance();
    end
    while (grant_log.size() < 3) grant_log.push_back(9);
    chk("t2 grant #1", grant_log[0], 0);
    chk("t2 grant #2", grant_log[1], 1);
    chk("t2 grant #3", grant_log[2], 0);

    // m1 burst of four reads while m0 waits
    idle(3);
    m_cyc[1] = 1; m_stb[1] = 1; m_adr[1] = 16'h0040;
    step();
    for (int k = 1; k <= 4; k++) exp_q.push_back(32'(k));
    n_ack0 = 0; n_ack1 = 0;
    for (int k = 1; k <= 4; k++) begin
      m_cyc[0] = 1; m_stb[0] = 1;
      s_ack_i = 1; s_dat_i = 32'(k);
      settle();
      chk("t3 grant", grant_o, 2'b10);
      if (m0_ack_o) n_ack0++;
      if (m1_ack_o) begin
        n_ack1++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("t3 rdata", m1_dat_o, e);
        end
      end
      advance();
    end
    chk("t3 m1 acks", n_ack1, 4);
    chk("t3 m0 acks", n_ack0, 0);
    m_cyc[1] = 0; m_stb[1] = 0; s_ack_i = 0;
    step();
    settle();
    chk("t3 dead cycle", grant_o, 2'b00);
    advance();

    // Watchdog timeout on m0 with m1 waiting
    m_cyc[1] = 1; m_we[0] = 1;
    for (int i = 0; i < TO; i++) begin
      settle();
      if (i == 0) chk("t3 m0 granted", grant_o, 2'b01);
      if (i < TO - 1) begin
        chk("t4 no early err", m0_err_o, 0);
      end else begin
        chk("t4 m0_err", m0_err_o, 1);
        chk("t4 s_stb", s_stb_o, 0);
        chk("t4 s_cyc", s_cyc_o, 0);
      end
      advance();
    end
    settle();
    chk("t4 idle", grant_o, 2'b00);
    advance();
    settle();
    chk("t4 m1 next", grant_o, 2'b10);
    advance();
    idle(3);

    // Ack lands in exactly the timeout cycle
    m_cyc[0] = 1; m_stb[0] = 1;
    step();
    for (int i = 0; i < TO; i++) begin
      s_ack_i = (i == TO - 1);
      settle();
      if (i == TO - 1) begin
        chk("t5 m0_ack", m0_ack_o, 1);
        chk("t5 m0_err", m0_err_o, 0);
      end
      advance();
    end
    idle(3);

    // Asynchronous reset in the middle of an m1 transfer
    m_cyc[1] = 1; m_stb[1] = 1; s_ack_i = 1; s_dat_i = 32'h5A5A_0001;
    step();
    settle();
    chk("t6 pre m1_ack", m1_ack_o, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6 s_cyc", s_cyc_o, 0);
    chk("t6 s_stb", s_stb_o, 0);
    chk("t6 m1_ack", m1_ack_o, 0);
    chk("t6 m1_err", m1_err_o, 0);
    chk("t6 grant", grant_o, 2'b00);
    advance();
    m_cyc[0] = 1; s_ack_i = 0;
    step();
    rst_n = 1'b1;
    settle();
    chk("t6 idle", grant_o, 2'b00);
    advance();
    settle();
    chk("t6 m0 wins tie", grant_o, 2'b01);
    advance();
    idle(3);

    // Random traffic from both masters against a random slave
    for (int blk = 0; blk < 6; blk++) begin
      case (blk % 4)
        0: pct = 60;
        1: pct = 5;
        2: pct = 30;
        default: pct = 0;
      endcase
      for (int c = 0; c < 500; c++) begin
        for (int i = 0; i < 2; i++) begin
          if (!m_cyc[i]) m_cyc[i] = ($urandom_range(0, 3) == 0);
          else           m_cyc[i] = ($urandom_range(0, 7) != 0);
          m_stb[i] = m_cyc[i] & 1'($urandom_range(0, 1));
          m_we[i]  = 1'($urandom_range(0, 1));
          m_sel[i] = 4'($urandom_range(0, 15));
          m_adr[i] = 16'($urandom);
          m_dat[i] = $urandom;
        end
        s_ack_i = ($urandom_range(0, 99) < pct);
        s_dat_i = $urandom;
        step();
      end
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_arb2_rr.md
Name: wb_arb2_rr

Overview:
- Two-master, one-slave Wishbone arbiter with round-robin fairness and a watchdog.
- Shares a single 32-bit Wishbone slave (e.g. a settings/output-pins register bank) between two requesters, such as the CPU and a host-command engine.
- Grant is held for a whole bus cycle (while the granted master's cyc is high).
- The watchdog terminates with err any transfer the slave never acks.

Parameters:
- DW, 32, data width (bits).
- AW, 16, address width (bits).
- SW, DW/8, select width (byte lanes).
- TIMEOUT, 255, maximum wait cycles for s_ack_i before err; range 1..65535, counter width 16.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_n_i  in  1  reset; asynchronous assert, active-low.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 control.
- m0_sel_i  in  SW  master 0 byte selects.
- m0_adr_i  in  AW  master 0 address.
- m0_dat_i  in  DW  master 0 write data.
- m0_dat_o  out  DW  read data to master 0.
- m0_ack_o, m0_err_o  out  1 each  master 0 termination.
- m1_*  same set as m0_*  master 1.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave control.
- s_sel_o  out  SW  slave byte selects.
- s_adr_o  out  AW  slave address.
- s_dat_o  out  DW  slave write data.
- s_dat_i  in  DW  slave read data.
- s_ack_i  in  1  slave ack.
- grant_o  out  2  one-hot owner: 01 = m0, 10 = m1, 00 = idle.

Behaviour:

Reset:
- While wb_rst_n_i = 0, all outputs are 0 immediately (asynchronous): s_cyc/stb/we/sel/adr/dat, both acks and errs, grant_o = 00.
- Internal state: IDLE, last_grant = m1 (so m0 wins the first tie), watchdog = 0.
- Reset asserted mid-transfer aborts the transfer; no ack or err is issued.

States:
- IDLE, OWN0, OWN1.
- Registered state; all routing is combinational from state.

IDLE:
- Only m0_cyc_i high -> OWN0.
- Only m1_cyc_i high -> OWN1.
- Both high -> the master that is not last_grant.
- On entering OWNx, last_grant <= x.
- No slave signals are driven in IDLE.
- Arbitration latency: one cycle, i.e. a request at cycle N drives s_cyc_o at N+1.

OWNx:
- s_cyc/stb/we/sel/adr/dat_o = mx_* inputs.
- mx_ack_o = s_ack_i & mx_stb_i.
- The other master's ack/err are 0.
- m0_dat_o = m1_dat_o = s_dat_i (broadcast; only meaningful with ack).
- Multiple beats (stb toggling) within one cyc stay in OWNx.
- mx_cyc_i falls -> IDLE next cycle; one dead cycle before any new grant, even if the other master is waiting.
- The ungranted master's inputs are ignored entirely.

Watchdog:
- In OWNx, increments each cycle while s_stb_o = 1 and s_ack_i = 0.
- Clears on s_ack_i, on s_stb_o = 0, and on leaving OWNx.
- Timeout cycle: the cycle in which the count equals TIMEOUT-1 and s_ack_i = 0.
  - mx_err_o = 1 for exactly that one cycle.
  - s_cyc_o and s_stb_o are forced to 0 in that same cycle.
  - State -> IDLE.
- s_ack_i in the timeout cycle wins: ack is given, no err.
- s_ack_i arriving after the timeout is ignored.
- If the erred master still holds cyc, it re-arbitrates normally: it loses to a waiting peer under round-robin.

Simultaneous events:
- Both masters raising cyc in the same cycle is resolved by last_grant.
- cyc falling in the same cycle as ack: the ack still passes through, then -> IDLE.

Test Plan:
- Reset release; m0 writes 0xDEADBEEF to adr 0x0004 with sel = 0xF, slave acks combinationally -> s_cyc_o rises 1 cycle after m0_cyc_i, s_dat_o = 0xDEADBEEF, m0_ack_o = 1, grant_o = 01, then 00.
- m0 and m1 both raise cyc on the same cycle after reset, each holding for 3 cycles -> m0 granted first; m1 granted after one dead IDLE cycle; a repeated tie then goes to m0 (alternation m0, m1, m0).
- m1 holds cyc for 4 read beats with s_dat_i = 0x1, 0x2, 0x3, 0x4 -> grant_o = 10 throughout, m1_ack_o pulses 4 times, m0_ack_o = 0, m0 request stalled until m1 drops cyc.
- TIMEOUT = 8, slave never acks m0 -> m0_err_o = 1 on the 8th cycle of stb, s_stb_o = 0 that cycle, next state IDLE; with m1 waiting, m1 is granted next.
- Slave acks in exactly the timeout cycle -> m0_ack_o = 1, m0_err_o = 0.
- wb_rst_n_i pulsed low mid-transfer in OWN1 -> all outputs 0 asynchronously, no ack/err; after release m0 wins the first tie.
